// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - Gray-step classification shared by the quadrature decoder
// Contents:
//   step_t          : STEP_NONE / STEP_FWD / STEP_REV / STEP_ILLEGAL
//   AB_IDLE         : detent rest code of the (A,B) pair
//   classify_step() : (previous AB, current AB) -> step_t, AB packed as {A,B}

package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    localparam logic [1:0] AB_IDLE = 2'b11;

    // Forward (right) order is 11 -> 10 -> 00 -> 01 -> 11. Any single-bit
    // change that is not the forward successor is the reverse predecessor,
    // so only the forward successor needs to be tabulated.
    function automatic step_t classify_step(input logic [1:0] prev_ab,
                                            input logic [1:0] cur_ab);
        logic [1:0] fwd_next;
        step_t      s;
        case (prev_ab)
            2'b11:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b00;
            2'b00:   fwd_next = 2'b01;
            default: fwd_next = 2'b11;
        endcase
        if (prev_ab == cur_ab) begin
            s = STEP_NONE;
        end else if ((prev_ab ^ cur_ab) == 2'b11) begin
            s = STEP_ILLEGAL;
        end else if (cur_ab == fwd_next) begin
            s = STEP_FWD;
        end else begin
            s = STEP_REV;
        end
        return s;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - 2-flop synchroniser and debounce for one A/B pin pair
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pins     : raw asynchronous pins, [0] = A, [1] = B
//   filt     : debounced pins, same bit order, idle 11 after reset

module quad_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pins,
    output logic [1:0] filt
);

    localparam int            CW   = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [1:0] sync1;
    logic [1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_pin
        logic [CW-1:0] cnt;
        logic          level;

        // The counter only runs while the synced pin disagrees with the
        // filtered value; any return to agreement restarts the window, so a
        // glitch shorter than FILT_LEN cycles never moves the output.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt   <= '0;
                level <= 1'b1;
            end else if (sync2[p] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2[p];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end

        assign filt[p] = level;
    end

endmodule

// File: rtl/quad_decoder_mc.sv
// rtl/quad_decoder_mc.sv - multi-channel quadrature decoder with detent events
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   rot      : raw pins, channel i A = rot[2i], B = rot[2i+1]
//   clr      : per-channel clear of position and sub-step accumulator
//   event_   : one-cycle pulse per completed detent
//   right_   : direction of the event (1 = right), 0 when no event
//   err      : one-cycle pulse when A and B change together
//   position : per-channel counter, channel i at [i*CNT_W +: CNT_W]

module quad_decoder_mc
    import quad_pkg::*;
#(
    parameter int N_CH             = 2,
    parameter int FILT_LEN         = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int CNT_W            = 8,
    parameter int WRAP             = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*N_CH-1:0]       rot,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH-1:0]         event_,
    output logic [N_CH-1:0]         right_,
    output logic [N_CH-1:0]         err,
    output logic [N_CH*CNT_W-1:0]   position
);

    // The accumulator only ever holds -(STEPS-1)..(STEPS-1); 4 signed bits
    // cover the largest allowed detent of 4 steps.
    localparam logic signed [3:0] ACC_TOP = 4'(STEPS_PER_DETENT - 1);
    localparam logic signed [3:0] ACC_BOT = -ACC_TOP;
    localparam logic [CNT_W-1:0]  POS_MAX = {CNT_W{1'b1}};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]        filt;
        logic [1:0]        cur_ab;
        logic [1:0]        prev_ab;
        step_t             step;
        logic signed [3:0] acc_q, acc_d;
        logic [CNT_W-1:0]  pos_q, pos_d;
        logic              ev_q, ev_d;
        logic              rt_q, rt_d;
        logic              er_q, er_d;

        quad_filter #(
            .FILT_LEN (FILT_LEN)
        ) u_filter (
            .clk  (clk),
            .rst  (rst),
            .pins (rot[2*i +: 2]),
            .filt (filt)
        );

        assign cur_ab = {filt[0], filt[1]};
        assign step   = classify_step(prev_ab, cur_ab);

        always_comb begin
            acc_d = acc_q;
            ev_d  = 1'b0;
            rt_d  = 1'b0;
            er_d  = 1'b0;
            case (step)
                STEP_FWD: begin
                    if (acc_q == ACC_TOP) begin
                        ev_d  = 1'b1;
                        rt_d  = 1'b1;
                        acc_d = '0;
                    end else begin
                        acc_d = acc_q + 4'sd1;
                    end
                end
                STEP_REV: begin
                    if (acc_q == ACC_BOT) begin
                        ev_d  = 1'b1;
                        acc_d = '0;
                    end else begin
                        acc_d = acc_q - 4'sd1;
                    end
                end
                STEP_ILLEGAL: begin
                    er_d  = 1'b1;
                    acc_d = '0;
                end
                default: ;
            endcase

            pos_d = pos_q;
            if (ev_d) begin
                if (rt_d) begin
                    if (WRAP != 0 || pos_q != POS_MAX) pos_d = pos_q + CNT_W'(1);
                end else begin
                    if (WRAP != 0 || pos_q != '0) pos_d = pos_q - CNT_W'(1);
                end
            end

            // clr overrides the counters but leaves the event pulse intact.
            if (clr[i]) begin
                acc_d = '0;
                pos_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                prev_ab <= AB_IDLE;
                acc_q   <= '0;
                pos_q   <= '0;
                ev_q    <= 1'b0;
                rt_q    <= 1'b0;
                er_q    <= 1'b0;
            end else begin
                prev_ab <= cur_ab;
                acc_q   <= acc_d;
                pos_q   <= pos_d;
                ev_q    <= ev_d;
                rt_q    <= rt_d;
                er_q    <= er_d;
            end
        end

        assign event_[i]                  = ev_q;
        assign right_[i]                  = rt_q;
        assign err[i]                     = er_q;
        assign position[i*CNT_W +: CNT_W] = pos_q;
    end

endmodule

// File: tb/tb_quad_decoder_mc.sv
// tb/tb_quad_decoder_mc.sv - self-checking bench for quad_decoder_mc

module tb_quad_decoder_mc;

    localparam int N_CH     = 2;
    localparam int FILT_LEN = 4;
    localparam int STEPS    = 4;
    localparam int CNT_W    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rot = 4'hf;
    logic [1:0]  clr = 2'b00;
    logic [1:0]  ev_w, rt_w, er_w, ev_s, rt_s, er_s;
    logic [15:0] pos_w, pos_s;

    always #5 clk = ~clk;

    quad_decoder_mc #(
        .N_CH(N_CH), .FILT_LEN(FILT_LEN), .STEPS_PER_DETENT(STEPS), .CNT_W(CNT_W), .WRAP(1)
    ) dut (
        .clk(clk), .rst(rst), .rot(rot), .clr(clr),
        .event_(ev_w), .right_(rt_w), .err(er_w), .position(pos_w)
    );

    quad_decoder_mc #(
        .N_CH(N_CH), .FILT_LEN(FILT_LEN), .STEPS_PER_DETENT(STEPS), .CNT_W(CNT_W), .WRAP(0)
    ) dut_sat (
        .clk(clk), .rst(rst), .rot(rot), .clr(clr),
        .event_(ev_s), .right_(rt_s), .err(er_s), .position(pos_s)
    );

    int total = 0;
    int bad   = 0;

    // Pulse counters, cumulative over the whole run.
    int evr_w[2], evl_w[2], err_w[2], evr_s[2], evl_s[2], err_s[2];
    int right_stray = 0;

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (ev_w[c]) begin
                if (rt_w[c]) evr_w[c]++; else evl_w[c]++;
            end else if (rt_w[c]) right_stray++;
            if (ev_s[c]) begin
                if (rt_s[c]) evr_s[c]++; else evl_s[c]++;
            end else if (rt_s[c]) right_stray++;
            if (er_w[c]) err_w[c]++;
            if (er_s[c]) err_s[c]++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ab is {A,B}; rot carries A in the even bit, B in the odd bit.
    function automatic logic [3:0] mk_rot(input logic [1:0] ab0, input logic [1:0] ab1);
        return {ab1[0], ab1[1], ab0[0], ab0[1]};
    endfunction

    task automatic measure_event(input int ch, output int lat, output int dir);
        lat = -1;
        dir = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lat < 0 && ev_w[ch]) begin
                lat = k - 1;
                dir = int'(rt_w[ch]);
            end
        end
    endtask

    typedef struct {
        logic [1:0] ab0;
        logic [1:0] ab1;
        int         pos0;
        int         pos1;
        int         spos1;
        int         errs0;
    } vec_t;

    vec_t tbl[22];

    // Reference model for the random phase: Gray index arithmetic.
    logic [1:0] gray [4];
    int m_idx[2], m_acc[2], m_pos[2], m_spos[2], m_r[2], m_l[2], m_e[2];
    int b_rw[2], b_lw[2], b_ew[2], b_rs[2], b_ls[2], b_es[2];

    task automatic model_step(input int c, input int d);
        if (d == 2) begin
            m_acc[c] = 0;
            m_e[c]++;
        end else if (d != 0) begin
            m_acc[c] += (d == 1) ? 1 : -1;
            if (m_acc[c] == STEPS) begin
                m_acc[c] = 0;
                m_r[c]++;
                m_pos[c] = (m_pos[c] + 1) % 256;
                if (m_spos[c] < 255) m_spos[c]++;
            end else if (m_acc[c] == -STEPS) begin
                m_acc[c] = 0;
                m_l[c]++;
                m_pos[c] = (m_pos[c] + 255) % 256;
                if (m_spos[c] > 0) m_spos[c]--;
            end
        end
    endtask

    initial begin
        int lat, dir, base_r, base_l, base_e;

        tbl[0]  = '{2'b10, 2'b11, 0, 0,   0, 0};
        tbl[1]  = '{2'b00, 2'b11, 0, 0,   0, 0};
        tbl[2]  = '{2'b01, 2'b11, 0, 0,   0, 0};
        tbl[3]  = '{2'b11, 2'b11, 1, 0,   0, 0};
        tbl[4]  = '{2'b11, 2'b01, 1, 0,   0, 0};
        tbl[5]  = '{2'b11, 2'b00, 1, 0,   0, 0};
        tbl[6]  = '{2'b11, 2'b10, 1, 0,   0, 0};
        tbl[7]  = '{2'b11, 2'b11, 1, 255, 0, 0};
        tbl[8]  = '{2'b10, 2'b11, 1, 255, 0, 0};
        tbl[9]  = '{2'b00, 2'b11, 1, 255, 0, 0};
        tbl[10] = '{2'b10, 2'b11, 1, 255, 0, 0};
        tbl[11] = '{2'b11, 2'b11, 1, 255, 0, 0};
        tbl[12] = '{2'b10, 2'b11, 1, 255, 0, 0};
        tbl[13] = '{2'b00, 2'b11, 1, 255, 0, 0};
        tbl[14] = '{2'b01, 2'b11, 1, 255, 0, 0};
        tbl[15] = '{2'b11, 2'b11, 2, 255, 0, 0};
        tbl[16] = '{2'b00, 2'b11, 2, 255, 0, 1};
        tbl[17] = '{2'b11, 2'b11, 2, 255, 0, 2};
        tbl[18] = '{2'b10, 2'b11, 2, 255, 0, 2};
        tbl[19] = '{2'b00, 2'b11, 2, 255, 0, 2};
        tbl[20] = '{2'b01, 2'b11, 2, 255, 0, 2};
        tbl[21] = '{2'b11, 2'b11, 3, 255, 0, 2};

        gray[0] = 2'b11; gray[1] = 2'b10; gray[2] = 2'b00; gray[3] = 2'b01;

        // Reset state
        cycles(3);
        chk("rst_event", int'(ev_w), 0);
        chk("rst_right", int'(rt_w), 0);
        chk("rst_err", int'(er_w), 0);
        chk("rst_pos", int'(pos_w), 0);
        chk("rst_pos_sat", int'(pos_s), 0);
        rst = 1'b0;
        cycles(2);

        // Table: right detent ch0, left detent ch1 (wrap / saturate),
        // mid-detent reversal, illegal jumps then a clean detent.
        for (int k = 0; k < 22; k++) begin
            rot = mk_rot(tbl[k].ab0, tbl[k].ab1);
            cycles(10);
            chk($sformatf("tbl%0d_pos0", k), int'(pos_w[7:0]), tbl[k].pos0);
            chk($sformatf("tbl%0d_pos1", k), int'(pos_w[15:8]), tbl[k].pos1);
            chk($sformatf("tbl%0d_sat_pos1", k), int'(pos_s[15:8]), tbl[k].spos1);
            chk($sformatf("tbl%0d_err0", k), err_w[0], tbl[k].errs0);
        end
        chk("tbl_right_events0", evr_w[0], 3);
        chk("tbl_left_events0", evl_w[0], 0);
        chk("tbl_left_events1", evl_w[1], 1);
        chk("tbl_sat_left_events1", evl_s[1], 1);
        chk("tbl_err1", err_w[1], 0);

        // Latency of the final step of a detent
        base_r = evr_w[0];
        rot = mk_rot(2'b10, 2'b11); cycles(10);
        rot = mk_rot(2'b00, 2'b11); cycles(10);
        rot = mk_rot(2'b01, 2'b11); cycles(10);
        rot = mk_rot(2'b11, 2'b11);
        measure_event(0, lat, dir);
        chk("lat_edges", lat, FILT_LEN + 2);
        chk("lat_dir", dir, 1);
        chk("lat_single_pulse", evr_w[0] - base_r, 1);
        chk("lat_pos0", int'(pos_w[7:0]), 4);

        // Glitches of 2 and 3 cycles on ch0 are filtered out
        base_r = evr_w[0] + evl_w[0];
        base_e = err_w[0];
        for (int g = 0; g < 8; g++) begin
            rot[0] = 1'b0; cycles(2); rot[0] = 1'b1; cycles(4);
            rot[1] = 1'b0; cycles(3); rot[1] = 1'b1; cycles(4);
        end
        cycles(10);
        chk("glitch_events", evr_w[0] + evl_w[0] - base_r, 0);
        chk("glitch_err", err_w[0] - base_e, 0);
        chk("glitch_pos0", int'(pos_w[7:0]), 4);

        // clr on the same edge the detent completes
        rot = mk_rot(2'b10, 2'b11); cycles(10);
        rot = mk_rot(2'b00, 2'b11); cycles(10);
        rot = mk_rot(2'b01, 2'b11); cycles(10);
        rot = mk_rot(2'b11, 2'b11);
        cycles(FILT_LEN + 2);
        clr = 2'b01;
        @(negedge clk);
        chk("clr_event", int'(ev_w[0]), 1);
        chk("clr_right", int'(rt_w[0]), 1);
        chk("clr_pos0", int'(pos_w[7:0]), 0);
        chk("clr_sat_pos0", int'(pos_s[7:0]), 0);
        chk("clr_pos1_kept", int'(pos_w[15:8]), 255);
        clr = 2'b00;
        cycles(3);
        chk("clr_pos0_after", int'(pos_w[7:0]), 0);
        clr = 2'b10;
        cycles(1);
        clr = 2'b00;
        chk("clr1_pos1", int'(pos_w[15:8]), 0);

        // rst in the middle of a detent
        rot = mk_rot(2'b10, 2'b11); cycles(10);
        rot = mk_rot(2'b00, 2'b11); cycles(10);
        rst = 1'b1;
        rot = 4'hf;
        cycles(2);
        chk("midrst_event", int'(ev_w), 0);
        chk("midrst_err", int'(er_w), 0);
        chk("midrst_pos", int'(pos_w), 0);
        chk("midrst_sat_pos", int'(pos_s), 0);
        rst = 1'b0;
        cycles(10);
        base_r = evr_w[0];
        base_l = evl_w[0];
        base_e = err_w[0];
        rot = mk_rot(2'b10, 2'b11); cycles(10);
        rot = mk_rot(2'b00, 2'b11); cycles(10);
        rot = mk_rot(2'b01, 2'b11); cycles(10);
        rot = mk_rot(2'b11, 2'b11); cycles(10);
        chk("postrst_right_events", evr_w[0] - base_r, 1);
        chk("postrst_left_events", evl_w[0] - base_l, 0);
        chk("postrst_err", err_w[0] - base_e, 0);
        chk("postrst_pos0", int'(pos_w[7:0]), 1);

        // Randomised stepping on both channels against the model
        for (int c = 0; c < 2; c++) begin
            m_idx[c] = 0; m_acc[c] = 0; m_r[c] = 0; m_l[c] = 0; m_e[c] = 0;
            b_rw[c] = evr_w[c]; b_lw[c] = evl_w[c]; b_ew[c] = err_w[c];
            b_rs[c] = evr_s[c]; b_ls[c] = evl_s[c]; b_es[c] = err_s[c];
        end
        m_pos[0] = 1; m_spos[0] = 1;
        m_pos[1] = 0; m_spos[1] = 0;
        for (int it = 0; it < 150; it++) begin
            for (int c = 0; c < 2; c++) begin
                int r, d;
                r = int'($urandom_range(0, 9));
                d = (r < 4) ? 1 : (r < 8) ? 3 : (r == 8) ? 2 : 0;
                m_idx[c] = (m_idx[c] + d) % 4;
                model_step(c, d);
            end
            rot = mk_rot(gray[m_idx[0]], gray[m_idx[1]]);
            cycles(int'($urandom_range(8, 14)));
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("rnd%0d_ch%0d_pos", it, c), int'(pos_w[c*8 +: 8]), m_pos[c]);
                chk($sformatf("rnd%0d_ch%0d_sat_pos", it, c), int'(pos_s[c*8 +: 8]), m_spos[c]);
                chk($sformatf("rnd%0d_ch%0d_right", it, c), evr_w[c] - b_rw[c], m_r[c]);
                chk($sformatf("rnd%0d_ch%0d_left", it, c), evl_w[c] - b_lw[c], m_l[c]);
                chk($sformatf("rnd%0d_ch%0d_err", it, c), err_w[c] - b_ew[c], m_e[c]);
                chk($sformatf("rnd%0d_ch%0d_sat_events", it, c),
                    (evr_s[c] - b_rs[c]) + (evl_s[c] - b_ls[c]) + (err_s[c] - b_es[c]),
                    m_r[c] + m_l[c] + m_e[c]);
            end
        end

        chk("right_zero_without_event", right_stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
